// File: rtl/pipe_pkg.sv
// Shared types and defaults for pipeline stage registers.
package pipe_pkg;

    localparam int unsigned DefaultWidth = 64;

    // Stage fill level derived from the main/skid valid bits.
    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;

endpackage

// File: rtl/en_reg_var.sv
// Enable-gated register of arbitrary width with synchronous active-low reset.
module en_reg_var #(
    parameter int unsigned     WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RESET_DATA;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer;
// in_ready comes straight from a flop so out_ready never reaches it combinationally.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             xfer_in, xfer_out;
    pipe_state_t      state;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = main_valid_q & out_ready;

    always_comb begin
        if (skid_valid_q) begin
            state = PS_TWO;
        end else if (main_valid_q) begin
            state = PS_ONE;
        end else begin
            state = PS_EMPTY;
        end
    end

    // Data enables stay low on flush so held payloads are left untouched.
    always_comb begin
        main_en      = 1'b0;
        skid_en      = 1'b0;
        main_d       = in_data;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (xfer_in) begin
                        main_en      = 1'b1;
                        main_valid_d = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_en = 1'b1;
                    end else if (xfer_in) begin
                        skid_en      = 1'b1;
                        skid_valid_d = 1'b1;
                    end else if (xfer_out) begin
                        main_valid_d = 1'b0;
                    end
                end
                PS_TWO: begin
                    if (xfer_out) begin
                        main_en      = 1'b1;
                        main_d       = skid_data;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    en_reg_var #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_data)
    );

    en_reg_var #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_data)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [1:0]  occupancy;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  occupancy8;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(
        .WIDTH      (8),
        .RESET_DATA (8'h5A)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_data   (in_data[7:0]),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_data  (out_data8),
        .occupancy (occupancy8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of at most two entries; the head register keeps
    // its last payload whenever the stage is empty.
    logic [63:0] q[$];
    logic [63:0] hold;
    logic [7:0]  hold8;
    logic        model_live = 1'b0;
    logic        acc_in_last = 1'b0;
    int unsigned sz;
    logic        acc_in, acc_out;

    always @(posedge clk) begin
        sz      = q.size();
        acc_in  = 1'b0;
        acc_out = 1'b0;
        if (!reset) begin
            q.delete();
            hold       = 64'h0;
            hold8      = 8'h5A;
            model_live = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            acc_out = out_ready && (sz > 0);
            acc_in  = in_valid && (sz < 2);
            if (acc_out) void'(q.pop_front());
            if (acc_in) q.push_back(in_data);
        end
        acc_in_last = acc_in;
        if (q.size() > 0) begin
            hold  = q[0];
            hold8 = q[0][7:0];
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
            chk("in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
            chk("occupancy", {62'b0, occupancy}, 64'(q.size()));
            chk("out_data", out_data, hold);
            chk("occupancy8", {62'b0, occupancy8}, 64'(q.size()));
            chk("out_data8", {56'b0, out_data8}, {56'b0, hold8});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    initial begin
        // Reset with a pending offer that must be ignored.
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hDEAD;
        tick(); tick();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_occ", {62'b0, occupancy}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_data8", {56'b0, out_data8}, 64'h5A);
        reset = 1'b1; in_valid = 1'b0;
        tick();

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push(64'(i));
            chk("stream_data", out_data, 64'(i));
            chk("stream_occ", {62'b0, occupancy}, 64'd1);
            chk("stream_rdy", {63'b0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {63'b0, out_valid}, 64'd0);

        // Backpressure fills the skid; third offer must wait.
        out_ready = 1'b0;
        push(64'hA);
        push(64'hB);
        chk("skid_occ", {62'b0, occupancy}, 64'd2);
        chk("skid_rdy", {63'b0, in_ready}, 64'd0);
        push(64'hC);
        chk("skid_hold_data", out_data, 64'hA);
        chk("skid_hold_occ", {62'b0, occupancy}, 64'd2);
        out_ready = 1'b1;
        tick();
        chk("skid_pop1", out_data, 64'hB);
        tick();
        chk("skid_pop2", out_data, 64'hC);
        in_valid = 1'b0;
        tick();
        chk("skid_empty", {62'b0, occupancy}, 64'd0);

        // Simultaneous push and pop while holding one entry.
        out_ready = 1'b0;
        push(64'h5);
        out_ready = 1'b1;
        push(64'h6);
        chk("swap_data", out_data, 64'h6);
        chk("swap_occ", {62'b0, occupancy}, 64'd1);
        in_valid = 1'b0;
        tick();

        // Flush from two entries with a concurrent offer.
        out_ready = 1'b0;
        push(64'h7);
        push(64'h8);
        flush = 1'b1; in_data = 64'h9;
        tick();
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_occ", {62'b0, occupancy}, 64'd0);
        chk("flush_rdy", {63'b0, in_ready}, 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_no9", {62'b0, occupancy}, 64'd0);
        chk("flush_data_kept", out_data, 64'h7);

        // Flush from one entry where in_ready is high: offer still discarded.
        push(64'h11);
        flush = 1'b1; in_data = 64'h12;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush1_occ", {62'b0, occupancy}, 64'd0);
        chk("flush1_data", out_data, 64'h11);

        // Reset beats flush and handshakes.
        push(64'h21);
        reset = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = 64'h22;
        tick();
        chk("rstpri_valid", {63'b0, out_valid}, 64'd0);
        chk("rstpri_occ", {62'b0, occupancy}, 64'd0);
        chk("rstpri_data", out_data, 64'd0);
        chk("rstpri_data8", {56'b0, out_data8}, 64'h5A);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        tick();

        // Random traffic; a pending offer is held until accepted.
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !acc_in_last)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 127) != 0);
            tick();
        end
        reset = 1'b1; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
